regfile_mport: RTL and testbench
================================

Name: regfile_mport

Overview:
Parametrised register file for the RISC5 CPU, generalising the fixed 3-read/1-write 16x32 file.
- One copy of block RAM per read port, all sharing the write port.
- Synchronous reads with 1-cycle latency.
- After reset, a hardware clear sweep zeroes every register, since the RAM contents themselves cannot be reset.
- Optional write-to-read forwarding.
- Sits between the CPU decode stage and the ALU operand muxes.

Parameters:
DW, 32, data width in bits
AW, 4, address width; depth = 2**AW registers
NRD, 3, number of read ports (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr  in  1  write enable (ignored while busy)
wa  in  AW  write address
din  in  DW  write data
ra  in  NRD*AW  packed read addresses; port k = ra[k*AW +: AW]
dout  out  NRD*DW  packed read data; port k = dout[k*DW +: DW]
busy  out  1  high while clear sweep is in progress

Behaviour:
- Storage: NRD identical arrays of 2**AW x DW.
  - Every accepted write goes to all NRD arrays at wa.
  - Read port k reads only array k.
- Read timing: at rising edge t, ra[k] is sampled; dout[k] holds that register's value from edge t onward, until edge t+1.
- Write timing: when wr=1 and busy=0 at edge t, array[wa] <= din at edge t. A read sampled at edge t+1 or later sees the new value.
- Same-address read/write at the same edge:
  - without forwarding: dout returns the OLD contents (read-before-write);
  - with forwarding: see Optional Feature.
- Multiple read ports may address the same register; all return identical data.
- State machine: CLEAR, RUN.
  - rst=1 at an edge: state <= CLEAR, cnt <= 0, busy <= 1, all dout <= 0. Applies regardless of current state; reset mid-sweep restarts from address 0.
  - CLEAR, rst=0: each edge writes 0 to address cnt in all arrays, cnt <= cnt+1.
    - wr is ignored.
    - dout is held at 0.
    - When cnt = 2**AW-1 is written, state <= RUN and busy <= 0 at that same edge.
  - Sweep length: exactly 2**AW cycles after rst deasserts (16 for defaults).
  - RUN: normal operation; stays in RUN until rst.
- cnt is AW bits wide and wraps only at the terminal transition.
- Reset values: busy=1, dout=all zeros, state=CLEAR, cnt=0.
- First read valid: first edge with busy=0 samples ra; dout is valid after that edge.
- No combinational path from any input to dout or busy; all outputs are registered.

Optional Feature:
Macro REGFILE_MPORT_FWD_EN.
- Defined: per port k, a registered bypass flag is set when wr=1, busy=0 and wa == ra[k] at the sampling edge, and DW bits of din are captured alongside. dout[k] then shows the captured din instead of the array output, so a same-edge write is visible with 1-cycle latency.
- Undefined: no bypass logic; read-before-write as specified above.

Test Plan:
- Reset sweep: pulse rst 1 cycle, then write nothing -> busy high for exactly 16 cycles after rst falls; reading all 16 addresses on all 3 ports then returns 0x00000000.
- Basic write/read: write 0xDEADBEEF to r5, then next cycle ra={5,5,5} -> all three dout = 0xDEADBEEF one edge after sampling.
- Independent ports: r1=0x11, r2=0x22, r3=0x33 written; ra={3,1,2} -> dout = {0x33,0x11,0x22}.
- Same-edge collision: r7=0xAAAA0000, then wr r7=0x5555FFFF with ra[0]=7 at the same edge -> dout[0]=0xAAAA0000 without macro, 0x5555FFFF with REGFILE_MPORT_FWD_EN; the next read of r7 returns 0x5555FFFF in both builds.
- Writes during CLEAR: wr=1, wa=4, din=0x12345678 on cycles 0..5 after rst falls -> ignored; after busy falls, r4 reads 0.
- Reset mid-sweep: assert rst at cycle 8 of the sweep -> busy stays high, sweep restarts; busy falls 16 cycles after the second rst deassertion; all registers read 0.

Source files
------------

// File: rtl/regfile_mport.sv
// regfile_mport: NRD-read / 1-write register file, one RAM copy per read port,
// zeroed by a clear sweep after reset. Define REGFILE_MPORT_FWD_EN for write-to-read forwarding.
module regfile_mport #(
    parameter int DW  = 32,
    parameter int AW  = 4,
    parameter int NRD = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     din,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] dout,
    output logic              busy
);
    localparam int DEPTH = 2**AW;
    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_d;
    logic [AW-1:0] cnt, cnt_d;
    logic          busy_d;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    // Shared write port: the clear sweep owns it while in CLEAR.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state;
        cnt_d   = cnt;
        busy_d  = busy;
        mem_we  = 1'b0;
        mem_wa  = wa;
        mem_wd  = din;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = '0;
                cnt_d  = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                mem_we = wr;
                busy_d = 1'b0;
            end
            default: state_d = CLEAR;
        endcase
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_q;

        // NOTE: the array has no reset (block RAM cannot be reset); the clear sweep zeroes it instead.
        always_ff @(posedge clk) begin
            if (mem_we) mem[mem_wa] <= mem_wd;
        end

        // Same-edge write is not visible here: the read samples the old word.
        always_ff @(posedge clk) begin
            if (rst || state == CLEAR) rd_q <= '0;
            else                       rd_q <= mem[ra[k*AW +: AW]];
        end

`ifdef REGFILE_MPORT_FWD_EN
        logic          byp_q;
        logic [DW-1:0] byp_data;

        always_ff @(posedge clk) begin
            if (rst || state == CLEAR) begin
                byp_q <= 1'b0;
            end else begin
                byp_q    <= wr && (wa == ra[k*AW +: AW]);
                byp_data <= din;
            end
        end

        assign dout[k*DW +: DW] = byp_q ? byp_data : rd_q;
`else
        assign dout[k*DW +: DW] = rd_q;
`endif
    end
endmodule

// File: tb/tb_regfile_mport.sv
// Self-checking bench for regfile_mport: reference model plus expected-read queue,
// one task per scenario.
module tb_regfile_mport;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NRD   = 3;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     din;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] dout;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]     model [DEPTH];
    logic [NRD*DW-1:0] exp_q [$];

    regfile_mport #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .wa   (wa),
        .din  (din),
        .ra   (ra),
        .dout (dout),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Counts edges until busy falls, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // One RUN-mode cycle: push the expected read data, drive, advance one edge.
    task automatic cycle(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        logic [NRD*DW-1:0] e;
        logic [AW-1:0]     rv [NRD];
        rv = '{r0, r1, r2};
        for (int k = 0; k < NRD; k++) begin
            e[k*DW +: DW] = model[rv[k]];
`ifdef REGFILE_MPORT_FWD_EN
            if (w && a == rv[k]) e[k*DW +: DW] = d;
`endif
        end
        exp_q.push_back(e);
        wr  = w;
        wa  = a;
        din = d;
        ra  = {r2, r1, r0};
        tick();
        if (w) model[a] = d;
        wr = 1'b0;
    endtask

    task automatic test_reset;
        logic [NRD*DW-1:0] e;
        int n;
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++;
        if (dout !== '0) begin failures++; $display("FAIL reset_dout: got %h expected 0", dout); end
        rst = 1'b0;
        wait_idle(n);
        checks++;
        if (n != 16) begin failures++; $display("FAIL sweep_len: got %0d expected 16", n); end
        clear_model();
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, '0, '0, AW'(a), AW'(a), AW'(a));
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin failures++; $display("FAIL sweep_zero[%0d]: got %h expected %h", a, dout, e); end
        end
    endtask

    task automatic test_basic;
        logic [NRD*DW-1:0] e;
        cycle(1'b1, 4'd5, 32'hDEADBEEF, 4'd0, 4'd0, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL basic_wr: got %h expected %h", dout, e); end
        cycle(1'b0, '0, '0, 4'd5, 4'd5, 4'd5);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL basic_rd: got %h expected %h", dout, e); end
    endtask

    task automatic test_ports;
        logic [NRD*DW-1:0] e;
        cycle(1'b1, 4'd1, 32'h11, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 4'd2, 32'h22, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 4'd3, 32'h33, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        cycle(1'b0, '0, '0, 4'd2, 4'd1, 4'd3);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL ports: got %h expected %h", dout, e); end
    endtask

    task automatic test_collision;
        logic [NRD*DW-1:0] e;
        cycle(1'b1, 4'd7, 32'hAAAA0000, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 4'd7, 32'h5555FFFF, 4'd7, 4'd5, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL collide: got %h expected %h", dout, e); end
        cycle(1'b0, '0, '0, 4'd7, 4'd7, 4'd7);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL collide_after: got %h expected %h", dout, e); end
    endtask

    task automatic test_back_to_back;
        logic [NRD*DW-1:0] e;
        cycle(1'b1, 4'd10, 32'hCAFE0010, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 4'd11, 32'hCAFE0011, 4'd10, 4'd11, 4'd10);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL b2b_1: got %h expected %h", dout, e); end
        cycle(1'b1, 4'd15, 32'hFFFF000F, 4'd11, 4'd10, 4'd15);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL b2b_2: got %h expected %h", dout, e); end
        cycle(1'b0, '0, '0, 4'd15, 4'd11, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL b2b_3: got %h expected %h", dout, e); end
    endtask

    task automatic test_clear_writes;
        logic [NRD*DW-1:0] e;
        int n;
        int m;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            wr  = 1'b1;
            wa  = 4'd4;
            din = 32'h12345678;
            tick();
            n++;
            checks++;
            if (busy !== 1'b1 || dout !== '0) begin
                failures++;
                $display("FAIL clear_hold[%0d]: got busy=%b dout=%h expected busy=1 dout=0", i, busy, dout);
            end
        end
        wr = 1'b0;
        wait_idle(m);
        n += m;
        checks++;
        if (n != 16) begin failures++; $display("FAIL clear_wr_len: got %0d expected 16", n); end
        clear_model();
        cycle(1'b0, '0, '0, 4'd4, 4'd4, 4'd4);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL clear_wr_r4: got %h expected %h", dout, e); end
    endtask

    task automatic test_mid_reset;
        logic [NRD*DW-1:0] e;
        int n;
        cycle(1'b1, 4'd9, 32'h99999999, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 4'd0, 32'h00000001, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        cycle(1'b1, 4'd15, 32'hF0F0F0F0, 4'd0, 4'd0, 4'd0);
        void'(exp_q.pop_front());
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || dout !== '0) begin
            failures++;
            $display("FAIL mid_rst: got busy=%b dout=%h expected busy=1 dout=0", busy, dout);
        end
        rst = 1'b0;
        wait_idle(n);
        checks++;
        if (n != 16) begin failures++; $display("FAIL mid_len: got %0d expected 16", n); end
        clear_model();
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, '0, '0, AW'(a), AW'(DEPTH - 1 - a), AW'(a));
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin failures++; $display("FAIL mid_zero[%0d]: got %h expected %h", a, dout, e); end
        end
    endtask

    initial begin
        rst = 1'b1;
        wr  = 1'b0;
        wa  = '0;
        din = '0;
        ra  = '0;
        test_reset();
        test_basic();
        test_ports();
        test_collision();
        test_back_to_back();
        test_clear_writes();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
